vga_fetch_responder: RTL and testbench
======================================

// Module: vga_fetch_responder
// PURPOSE
//  Bus responder for the video fetch port. Serves word reads issued by the scanline
//  fetcher (bus_read/address/bus_wait/data) from an external 16-bit asynchronous SRAM.
//  Each 24-bit pixel word takes two SRAM half-word reads, with programmable wait states.
//  Sits between the framebuffer fetch engine and the video SRAM pins, in the vga clock domain.
// PARAMETERS
//  BASE   32'h00c00000  first byte address of the video window (pixel word 0)
//  WORDS  32'h00080000  window size in pixel words; addresses >= BASE+WORDS miss
//  AW     20            SRAM half-word address width
//  WAIT   1             extra cycles each SRAM read is held before sampling (0..15)
// PORTS
//  clock       in   1   vga clock; all state on rising edge
//  reset_n     in   1   asynchronous active-low reset
//  bus_read    in   1   fetcher request; held high across back-to-back word reads
//  address     in   32  pixel word address (BASE + word index), one index per pixel
//  bus_wait    out  1   high = data not ready; low for exactly one cycle = data valid
//  data        out  24  pixel {r,g,b}; registered, holds value until next completion
//  sram_addr   out  AW  SRAM half-word address
//  sram_ce_n   out  1   SRAM chip enable, active low
//  sram_oe_n   out  1   SRAM output enable, active low
//  sram_dq     in   16  SRAM read data
// BEHAVIOUR
//  Reset: bus_wait=1, data=0, sram_addr=0, sram_ce_n=1, sram_oe_n=1, state=IDLE, waitcnt=0.
//  States: IDLE, LO, HI, DONE, RECOVER.
//  IDLE: bus_wait=1. If bus_read=1: off = address - BASE (32-bit, unsigned).
//   off < WORDS -> LO, sram_addr={off[AW-2:0],1'b0}, ce_n=oe_n=0, waitcnt=WAIT.
//   off >= WORDS (includes address < BASE via wrap) -> DONE, data=24'h000000.
//  LO: hold sram_addr, ce_n=oe_n=0. While waitcnt!=0 decrement. At waitcnt==0 capture
//   lo=sram_dq, sram_addr[0]=1, waitcnt=WAIT, -> HI.
//  HI: same counting. At waitcnt==0 data={sram_dq[7:0],lo[15:0]}, ce_n=oe_n=1, -> DONE.
//   sram_dq[15:8] of the high half-word is ignored.
//  DONE: bus_wait=0 for this one cycle only; data valid. -> RECOVER if bus_read=1, else IDLE.
//  RECOVER: bus_wait=1, address NOT sampled (fetcher updates address during this cycle).
//   -> IDLE next cycle.
//  Latency: request first seen in IDLE at cycle S -> bus_wait low at S+2*(WAIT+1)+1
//   (S+5 for WAIT=1); miss -> S+1. Throughput: one word per 2*(WAIT+1)+3 cycles.
//  bus_read drops in LO/HI: abort; ce_n=oe_n=1 next edge, -> IDLE, data unchanged,
//   no completion pulse. bus_read drops in DONE: pulse still occurs, -> IDLE.
//  Address changes during LO/HI are ignored (offset latched in IDLE).
//  Asynchronous reset mid-access: all outputs to reset values immediately; SRAM deselected.
//  bus_wait, data, sram_* are registered outputs (no combinational path from inputs).
// TESTING
//  1 Reset: assert reset_n=0 mid-HI -> bus_wait=1, ce_n=oe_n=1, data=0 same cycle.
//  2 Single read WAIT=1: address=32'h00c00003, SRAM[6]=16'hBEEF, SRAM[7]=16'h12AB
//    -> sram_addr 6 then 7, each held 2 cycles; data=24'hABBEEF, bus_wait low at S+5 for 1 cycle.
//  3 Back-to-back: model fetcher (hold bus_read, bump address the cycle after completion)
//    over 640 words -> every word matches memory model; no word skipped or repeated.
//  4 Miss: address=32'h00bffffc and 32'h00c80000 -> no SRAM access (ce_n stays 1),
//    data=24'h000000, bus_wait low at S+1.
//  5 Abort: drop bus_read during LO -> no bus_wait low pulse, ce_n=1 next cycle, IDLE.
//  6 WAIT=0 and WAIT=15 builds: completion at S+3 and S+33 respectively; data correct.

Source files
------------

// File: rtl/vga_fetch_responder_if.sv
// Video fetch port: scanline fetcher (master) to SRAM responder (slave).
// bus_wait low for one cycle marks data valid.
interface vga_fetch_responder_if;
  logic        bus_read;
  logic [31:0] address;
  logic        bus_wait;
  logic [23:0] data;

  modport master (
    output bus_read,
    output address,
    input  bus_wait,
    input  data
  );

  modport slave (
    input  bus_read,
    input  address,
    output bus_wait,
    output data
  );
endinterface

// File: rtl/vga_fetch_responder.sv
// Video fetch responder: one 24-bit pixel word from two 16-bit
// asynchronous SRAM half-word reads with programmable wait states.
module vga_fetch_responder #(
  parameter logic [31:0] BASE  = 32'h00c00000,
  parameter logic [31:0] WORDS = 32'h00080000,
  parameter int unsigned AW    = 20,
  parameter int unsigned WAIT  = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  vga_fetch_responder_if.slave  bus,
  output logic [AW-1:0]         sram_addr,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  input  logic [15:0]           sram_dq
);

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    DONE,
    RECOVER
  } state_t;

  localparam logic [3:0] WAIT_V = 4'(WAIT);

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [15:0]   lo_q, lo_d;
  logic [23:0]   data_q, data_d;
  logic          wait_q, wait_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ce_q, ce_d;
  logic [31:0]   off;
  logic          hit;

  // Unsigned wrap makes addresses below BASE land far above WORDS.
  assign off = bus.address - BASE;
  assign hit = off < WORDS;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    data_d  = data_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    ce_d    = ce_q;
    unique case (state_q)
      IDLE: begin
        if (bus.bus_read) begin
          if (hit) begin
            state_d = LO;
            addr_d  = {off[AW-2:0], 1'b0};
            ce_d    = 1'b1;
            cnt_d   = WAIT_V;
          end else begin
            state_d = DONE;
            data_d  = 24'h000000;
            wait_d  = 1'b0;
          end
        end
      end
      LO: begin
        if (!bus.bus_read) begin
          state_d = IDLE;
          ce_d    = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          lo_d      = sram_dq;
          addr_d[0] = 1'b1;
          cnt_d     = WAIT_V;
          state_d   = HI;
        end
      end
      HI: begin
        if (!bus.bus_read) begin
          state_d = IDLE;
          ce_d    = 1'b0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          data_d  = {sram_dq[7:0], lo_q};
          ce_d    = 1'b0;
          wait_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        wait_d  = 1'b1;
        state_d = bus.bus_read ? RECOVER : IDLE;
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        ce_d    = 1'b0;
        wait_d  = 1'b1;
      end
    endcase
  end

  // ce_q is the active-high select; both strobes share it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      lo_q    <= 16'h0000;
      data_q  <= 24'h000000;
      wait_q  <= 1'b1;
      addr_q  <= '0;
      ce_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      wait_q  <= wait_d;
      addr_q  <= addr_d;
      ce_q    <= ce_d;
    end
  end

  assign bus.bus_wait = wait_q;
  assign bus.data     = data_q;
  assign sram_addr    = addr_q;
  assign sram_ce_n    = ~ce_q;
  assign sram_oe_n    = ~ce_q;

endmodule

// File: tb/tb_vga_fetch_responder.sv
// Bench: three responders (WAIT 1, 0, 15) against a cycle-timeline model
// of each access, plus literal checks of latency and data.
module tb_vga_fetch_responder;

  localparam logic [31:0] BASE  = 32'h00c00000;
  localparam logic [31:0] WORDS = 32'h00080000;
  localparam int AW = 20;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [15:0]   mem [0:(1<<AW)-1];
  logic [2:0]    rd, bw, ce, oe;
  logic [31:0]   ad [3];
  logic [23:0]   dt [3];
  logic [AW-1:0] sa [3];
  logic [15:0]   dq [3];

  for (genvar g = 0; g < 3; g++) begin : ch
    localparam int WV = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    vga_fetch_responder_if bus ();
    assign bus.bus_read = rd[g];
    assign bus.address  = ad[g];
    assign bw[g] = bus.bus_wait;
    assign dt[g] = bus.data;
    assign dq[g] = (!ce[g] && !oe[g]) ? mem[sa[g]] : 16'h0000;
    vga_fetch_responder #(
      .BASE(BASE), .WORDS(WORDS), .AW(AW), .WAIT(WV)
    ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus),
      .sram_addr(sa[g]),
      .sram_ce_n(ce[g]),
      .sram_oe_n(oe[g]),
      .sram_dq(dq[g])
    );
  end

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Model: expected completion cycle, SRAM select window and data.
  int            done_c [3];
  int            ce_from [3];
  int            ce_to [3];
  int            split_c [3];
  logic [AW-1:0] lo_a [3];
  logic [23:0]   pend [3];
  logic [23:0]   mdl [3];

  function automatic int wv(int k);
    return (k == 0) ? 1 : ((k == 1) ? 0 : 15);
  endfunction

  function automatic logic [23:0] word_of(logic [31:0] a);
    logic [31:0] off;
    int unsigned h;
    off = a - BASE;
    if (off >= WORDS) return 24'h000000;
    h = off * 2;
    return {mem[h+1][7:0], mem[h]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      done_c[k]  = -1;
      ce_from[k] = 1;
      ce_to[k]   = 0;
      split_c[k] = 0;
      lo_a[k]    = '0;
      pend[k]    = 24'h0;
      mdl[k]     = 24'h0;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clock);
      if (chk_en) begin
        for (int k = 0; k < 3; k++) begin
          int c;
          bit on;
          c = cyc;
          if (c == done_c[k]) mdl[k] = pend[k];
          on = (c >= ce_from[k]) && (c <= ce_to[k]);
          check($sformatf("bus_wait ch%0d", k), 32'(bw[k]),
                32'(c != done_c[k]));
          check($sformatf("data ch%0d", k), 32'(dt[k]), 32'(mdl[k]));
          check($sformatf("ce_n ch%0d", k), 32'(ce[k]), 32'(!on));
          check($sformatf("oe_n ch%0d", k), 32'(oe[k]), 32'(!on));
          if (on)
            check($sformatf("sram_addr ch%0d", k), 32'(sa[k]),
                  32'(lo_a[k]) + 32'(c >= split_c[k]));
        end
      end
    end
  endtask

  // Request presented in the current cycle S; DUT must be idle.
  task automatic start(input int k, input logic [31:0] a, output int d);
    int s;
    logic [31:0] off;
    s = cyc;
    off = a - BASE;
    rd[k] = 1'b1;
    ad[k] = a;
    if (off < WORDS) begin
      d          = s + 2 * (wv(k) + 1) + 1;
      ce_from[k] = s + 1;
      ce_to[k]   = d - 1;
      split_c[k] = s + wv(k) + 2;
      lo_a[k]    = AW'(off * 2);
    end else begin
      d          = s + 1;
      ce_from[k] = 1;
      ce_to[k]   = 0;
    end
    pend[k]   = word_of(a);
    done_c[k] = d;
  endtask

  task automatic do_read(input int k, input logic [31:0] a, input bit drop);
    int d;
    start(k, a, d);
    while (cyc < d) step();
    if (drop) begin
      rd[k] = 1'b0;
      step();
    end else begin
      step();
      rd[k] = 1'b0;
      step();
    end
  endtask

  task automatic do_abort(input int k, input logic [31:0] a, input int j);
    int d;
    int s;
    s = cyc;
    start(k, a, d);
    done_c[k] = -1;
    ce_to[k]  = s + j;
    repeat (j) step();
    rd[k] = 1'b0;
    step();
  endtask

  task automatic b2b(input int k, input logic [31:0] a0, input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      start(k, a0 + 32'(i), d);
      while (cyc < d) step();
      step();
      if (i == n - 1) rd[k] = 1'b0;
      else ad[k] = a0 + 32'(i + 1);
      step();
    end
  endtask

  task automatic lit_lat(input int k, input int lat, input logic [23:0] v);
    for (int i = 0; i <= lat; i++) begin
      @(negedge clock);
      if (i == lat - 1)
        check($sformatf("latency-1 wait ch%0d", k), 32'(bw[k]), 32'd1);
      if (i == lat) begin
        check($sformatf("latency wait ch%0d", k), 32'(bw[k]), 32'd0);
        check($sformatf("latency data ch%0d", k), 32'(dt[k]), 32'(v));
      end
    end
  endtask

  task automatic rand_ops(input int k, input int n);
    for (int i = 0; i < n; i++) begin
      int r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        a = BASE + $urandom_range(0, WORDS - 1);
        do_read(k, a, 1'($urandom_range(0, 1)));
      end else if (r < 7) begin
        if ($urandom_range(0, 1) == 1)
          a = BASE - 32'd1 - $urandom_range(0, 255);
        else
          a = BASE + WORDS + $urandom_range(0, 255);
        do_read(k, a, 1'($urandom_range(0, 1)));
      end else if (r < 9) begin
        a = BASE + $urandom_range(0, WORDS - 1);
        do_abort(k, a, int'($urandom_range(1, 2 * (wv(k) + 1))));
      end else begin
        repeat ($urandom_range(1, 4)) step();
      end
    end
  endtask

  initial begin
    rd = 3'b000;
    for (int k = 0; k < 3; k++) ad[k] = 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
    mem[6]  = 16'hBEEF;
    mem[7]  = 16'h12AB;
    mem[20] = 16'h3344;
    mem[21] = 16'hFF55;
    mem[22] = 16'h7788;
    mem[23] = 16'h0066;
    model_reset();
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      check("reset bus_wait", 32'(bw[k]), 32'd1);
      check("reset data", 32'(dt[k]), 32'd0);
      check("reset sram_addr", 32'(sa[k]), 32'd0);
      check("reset ce_n", 32'(ce[k]), 32'd1);
      check("reset oe_n", 32'(oe[k]), 32'd1);
    end
    reset_n = 1'b1;
    chk_en = 1'b1;
    fork
      monitor();
    join_none

    fork
      do_read(0, 32'h00c00003, 1'b0);
      begin
        @(negedge clock);
        for (int i = 1; i <= 4; i++) begin
          @(negedge clock);
          check("single sram_addr", 32'(sa[0]), (i < 3) ? 32'd6 : 32'd7);
          check("single ce_n", 32'(ce[0]), 32'd0);
        end
        @(negedge clock);
        check("single bus_wait", 32'(bw[0]), 32'd0);
        check("single data", 32'(dt[0]), 32'h00ABBEEF);
        @(negedge clock);
        check("single pulse end", 32'(bw[0]), 32'd1);
      end
    join

    fork
      do_read(0, 32'h00bffffc, 1'b0);
      begin
        @(negedge clock);
        @(negedge clock);
        check("miss low bus_wait", 32'(bw[0]), 32'd0);
        check("miss low data", 32'(dt[0]), 32'd0);
        check("miss low ce_n", 32'(ce[0]), 32'd1);
      end
    join
    do_read(0, 32'h00c00003, 1'b1);
    fork
      do_read(0, 32'h00c80000, 1'b0);
      begin
        @(negedge clock);
        @(negedge clock);
        check("miss high bus_wait", 32'(bw[0]), 32'd0);
        check("miss high data", 32'(dt[0]), 32'd0);
      end
    join

    do_read(0, BASE + WORDS - 32'd1, 1'b0);
    do_read(0, BASE, 1'b1);

    fork
      do_abort(0, BASE + 32'd5, 1);
      begin
        @(negedge clock);
        @(negedge clock);
        check("abort ce_n in LO", 32'(ce[0]), 32'd0);
        @(negedge clock);
        check("abort ce_n after", 32'(ce[0]), 32'd1);
        check("abort no pulse", 32'(bw[0]), 32'd1);
        @(negedge clock);
        check("abort no pulse late", 32'(bw[0]), 32'd1);
      end
    join
    do_read(0, BASE + 32'd77, 1'b0);

    fork
      lit_lat(1, 3, 24'h553344);
      do_read(1, BASE + 32'd10, 1'b0);
      lit_lat(2, 33, 24'h667788);
      do_read(2, BASE + 32'd11, 1'b0);
    join

    fork
      b2b(0, BASE + 32'd100, 640);
      b2b(1, BASE + 32'd4000, 200);
      b2b(2, BASE + WORDS - 32'd20, 20);
    join

    fork
      rand_ops(0, 80);
      rand_ops(1, 80);
      rand_ops(2, 30);
    join

    begin
      int d;
      start(0, BASE + 32'd3, d);
      repeat (3) step();
      #2;
      chk_en = 1'b0;
      reset_n = 1'b0;
      #1;
      check("mid-HI reset bus_wait", 32'(bw[0]), 32'd1);
      check("mid-HI reset ce_n", 32'(ce[0]), 32'd1);
      check("mid-HI reset oe_n", 32'(oe[0]), 32'd1);
      check("mid-HI reset data", 32'(dt[0]), 32'd0);
      check("mid-HI reset sram_addr", 32'(sa[0]), 32'd0);
      rd[0] = 1'b0;
      step();
      reset_n = 1'b1;
      model_reset();
      chk_en = 1'b1;
    end
    do_read(0, 32'h00c00003, 1'b0);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
